game_screen_ctrl: RTL and testbench
===================================

Name: game_screen_ctrl

Overview:
Top-level screen sequencer for the tank game. It drives the object mux's hideMap/showEnd selects and gates all in-game object logic. It steps through four phases: open screen, play, post-kill delay, and end screen. Timing is counted in VGA frames from the frame-start pulse, and the block latches the match result for the end-screen winner graphic.

Parameters:
OPEN_MIN_FRAMES, 60, minimum frames the open screen is shown before startKey is accepted
END_DELAY_FRAMES, 30, frames the frozen map stays visible after a kill before the end overlay appears
END_SHOW_FRAMES, 300, frames the end overlay is shown before auto-return to the open screen
CNT_W, 9, frame counter width; must hold the largest frame parameter

Ports:
clk  in  1  system clock (pixel clock domain)
resetN  in  1  synchronous active-low reset
startOfFrame  in  1  one-cycle pulse per VGA frame
startKey  in  1  debounced start key, level
pauseKey  in  1  debounced pause key, level (used only with GAME_PAUSE_EN)
tank1Dead  in  1  one-cycle pulse, tank 1 destroyed
tank2Dead  in  1  one-cycle pulse, tank 2 destroyed
hideMap  out  1  1 = open screen layer, 0 = map layers
showEnd  out  1  1 = end overlay (winner/did/finally) enabled
gameActive  out  1  1 = tanks/missiles/buffs may move and fire
resetGame  out  1  one-cycle pulse that reinitialises all game objects
winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw
stateOut  out  3  encoded state, for debug/LEDs

Behaviour:
- Clock and reset: single clock clk. resetN is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - state = OPEN, frame counter = 0, winner = 00, resetGame = 0, startKey_d = 1 and pauseKey_d = 1 (a key held through reset does not count as a press).
  - Outputs in OPEN: hideMap = 1, showEnd = 0, gameActive = 0.
- Edge detect: startRise = startKey & ~startKey_d, and pauseRise is formed the same way. Both history registers update every cycle.
- Frame counter:
  - Increments on startOfFrame and saturates at all-ones.
  - Clears to 0 on the cycle of every state transition.
  - A startOfFrame that coincides with a transition is not counted.
- Outputs are Moore-decoded from the registered state, so they change on the same edge as the state. resetGame is registered.
- State encodings (stateOut): OPEN=0, LAUNCH=1, PLAY=2, END_DELAY=3, END_SHOW=4, PAUSE=5.
- OPEN (hideMap=1, showEnd=0, gameActive=0):
  - Goes to LAUNCH when startRise and counter >= OPEN_MIN_FRAMES.
  - A startRise that arrives earlier is dropped, not queued.
- LAUNCH (hideMap=0, gameActive=0):
  - Lasts exactly one cycle. resetGame = 1 and winner is cleared to 00.
  - Next state is always PLAY.
- PLAY (hideMap=0, showEnd=0, gameActive=1):
  - tank1Dead only: winner = 10, go to END_DELAY.
  - tank2Dead only: winner = 01, go to END_DELAY.
  - Both in the same cycle: winner = 11, go to END_DELAY.
  - winner is written on the transition edge.
- END_DELAY (hideMap=0, showEnd=0, gameActive=0):
  - Goes to END_SHOW when counter == END_DELAY_FRAMES.
  - Further death pulses are ignored and winner is frozen.
- END_SHOW (hideMap=0, showEnd=1, gameActive=0):
  - Goes to OPEN when counter == END_SHOW_FRAMES or on startRise, whichever comes first.
  - winner holds its value through OPEN and is cleared only in LAUNCH.
- A death pulse in any state other than PLAY has no effect.
- Reset mid-operation returns to OPEN on that edge with all reset values. No resetGame pulse is generated by reset itself.
- Counter comparisons are unsigned, CNT_W bits wide.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- With the macro defined:
  - pauseRise in PLAY goes to PAUSE (hideMap=0, showEnd=0, gameActive=0).
  - pauseRise in PAUSE returns to PLAY. The frame counter is not used in either state.
  - Death pulses in PAUSE are ignored.
  - startRise in PAUSE goes to LAUNCH (restart).
- Without the macro: PAUSE state and pauseKey_d are not built, pauseKey is unused, and stateOut never equals 5.

Test Plan:
- Reset with startKey held high: params OPEN_MIN_FRAMES=2, END_DELAY_FRAMES=3, END_SHOW_FRAMES=5; hold resetN=0 for 2 cycles then release with startKey=1 throughout -> hideMap=1, showEnd=0, gameActive=0, winner=00, stateOut=0, and no LAUNCH occurs.
- Early start: startRise after 1 frame -> stays OPEN. Release the key, wait 2 frames, press -> one cycle with stateOut=1 and resetGame=1, next cycle stateOut=2 and gameActive=1.
- Kill sequence: in PLAY pulse tank2Dead -> winner=01, stateOut=3, gameActive=0. After exactly 3 startOfFrame pulses showEnd=1. After 5 more frames stateOut=0, hideMap=1, winner still 01.
- Draw and ignored events: tank1Dead and tank2Dead in the same cycle -> winner=11. A tank1Dead pulse during END_DELAY leaves winner=11.
- Early exit and reset mid-game: startRise during END_SHOW after 1 frame -> OPEN on the next edge. resetN=0 during PLAY -> next edge stateOut=0, winner=00, resetGame=0.
- GAME_PAUSE_EN: pauseRise in PLAY -> stateOut=5, gameActive=0. tank1Dead in PAUSE -> no change. pauseRise again -> stateOut=2, gameActive=1.

Source files
------------

// File: rtl/game_screen_ctrl.sv
// game_screen_ctrl: top-level screen sequencer for the tank game.
// Steps open screen -> launch -> play -> post-kill delay -> end screen,
// timing each phase in VGA frames, and latches the match winner.
// Optional feature macro: GAME_PAUSE_EN (adds a PAUSE state driven by pauseKey).
//
// state      | meaning
// OPEN   (0) | title screen, map hidden, waits for a start press
// LAUNCH (1) | single cycle, pulses resetGame and clears winner
// PLAY   (2) | game running, watches for tank deaths
// END_DLY(3) | frozen map shown for END_DELAY_FRAMES after a kill
// END_SHW(4) | end overlay, leaves on timeout or start press
// PAUSE  (5) | game frozen (only with GAME_PAUSE_EN)
module game_screen_ctrl #(
  parameter int OPEN_MIN_FRAMES  = 60,
  parameter int END_DELAY_FRAMES = 30,
  parameter int END_SHOW_FRAMES  = 300,
  parameter int CNT_W            = 9
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       pauseKey,
  input  logic       tank1Dead,
  input  logic       tank2Dead,
  output logic       hideMap,
  output logic       showEnd,
  output logic       gameActive,
  output logic       resetGame,
  output logic [1:0] winner,
  output logic [2:0] stateOut
);

  localparam logic [2:0] S_OPEN      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_PLAY      = 3'd2;
  localparam logic [2:0] S_END_DELAY = 3'd3;
  localparam logic [2:0] S_END_SHOW  = 3'd4;
  localparam logic [2:0] S_PAUSE     = 3'd5;

  localparam logic [CNT_W-1:0] OPEN_MIN  = OPEN_MIN_FRAMES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DELAY_END = END_DELAY_FRAMES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] SHOW_END  = END_SHOW_FRAMES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       win_q, win_d;
  logic             rg_q, rg_d;
  logic             start_key_q;
  logic             start_rise;

  assign start_rise = startKey & ~start_key_q;

`ifdef GAME_PAUSE_EN
  logic pause_key_q;
  logic pause_rise;
  assign pause_rise = pauseKey & ~pause_key_q;
`else
  logic unused_pause_key;
  assign unused_pause_key = pauseKey;
`endif

  // Next-state, winner latch and resetGame decode.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      S_OPEN:
        if (start_rise && (cnt_q >= OPEN_MIN)) state_d = S_LAUNCH;
      S_LAUNCH:
        state_d = S_PLAY;
      S_PLAY: begin
        // A death outranks a pause press arriving in the same cycle.
        if (tank1Dead || tank2Dead) begin
          state_d = S_END_DELAY;
          win_d   = {tank1Dead, tank2Dead};
        end
`ifdef GAME_PAUSE_EN
        else if (pause_rise) state_d = S_PAUSE;
`endif
      end
      S_END_DELAY:
        if (cnt_q == DELAY_END) state_d = S_END_SHOW;
      S_END_SHOW:
        if ((cnt_q == SHOW_END) || start_rise) state_d = S_OPEN;
`ifdef GAME_PAUSE_EN
      S_PAUSE:
        if (start_rise)      state_d = S_LAUNCH;
        else if (pause_rise) state_d = S_PLAY;
`endif
      default:
        state_d = S_OPEN;
    endcase
    // Clearing on entry keeps winner at 00 for the whole visible LAUNCH cycle.
    if (state_d == S_LAUNCH) win_d = 2'b00;
    rg_d = (state_d == S_LAUNCH);
  end

  // Frame counter: clears on any transition, otherwise saturating frame count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)                      cnt_d = '0;
    else if (startOfFrame && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  // State, counter, winner and key-history registers.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= S_OPEN;
      cnt_q       <= '0;
      win_q       <= 2'b00;
      rg_q        <= 1'b0;
      start_key_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      rg_q        <= rg_d;
      start_key_q <= startKey;
    end
  end

`ifdef GAME_PAUSE_EN
  // Pause key history; preset so a key held through reset is not a press.
  always_ff @(posedge clk) begin
    if (!resetN) pause_key_q <= 1'b1;
    else         pause_key_q <= pauseKey;
  end
`endif

  assign hideMap    = (state_q == S_OPEN);
  assign showEnd    = (state_q == S_END_SHOW);
  assign gameActive = (state_q == S_PLAY);
  assign resetGame  = rg_q;
  assign winner     = win_q;
  assign stateOut   = state_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Bench for game_screen_ctrl: directed scenarios with literal expectations,
// then randomized stimulus, all tracked by a phase/frame reference model.
module tb_game_screen_ctrl;

  localparam int OMIN = 2;
  localparam int DLY  = 3;
  localparam int SHW  = 5;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, startKey, pauseKey, tank1Dead, tank2Dead;
  logic       hideMap, showEnd, gameActive, resetGame;
  logic [1:0] winner;
  logic [2:0] stateOut;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  game_screen_ctrl #(
    .OPEN_MIN_FRAMES(OMIN), .END_DELAY_FRAMES(DLY), .END_SHOW_FRAMES(SHW), .CNT_W(9)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startKey(startKey),
    .pauseKey(pauseKey), .tank1Dead(tank1Dead), .tank2Dead(tank2Dead),
    .hideMap(hideMap), .showEnd(showEnd), .gameActive(gameActive),
    .resetGame(resetGame), .winner(winner), .stateOut(stateOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase number (0 open,1 launch,2 play,3 delay,4 end,5 pause),
  // frames seen in the current phase, latched winner, start/pause key history.
  int m_ph = 0, m_fr = 0, m_win = 0, m_rg = 0, m_nx = 0;
  bit m_sk = 1'b1, m_pk = 1'b1, m_sr, m_pr;

  always @(posedge clk) begin
    if (!resetN) begin
      m_ph = 0; m_fr = 0; m_win = 0; m_rg = 0; m_sk = 1'b1; m_pk = 1'b1;
    end else begin
      m_sr = startKey && !m_sk;
      m_pr = PAUSE_ON && pauseKey && !m_pk;
      m_nx = m_ph;
      case (m_ph)
        0: if (m_sr && m_fr >= OMIN) m_nx = 1;
        1: m_nx = 2;
        2: if (tank1Dead || tank2Dead) begin
             m_nx  = 3;
             m_win = (tank1Dead ? 2 : 0) + (tank2Dead ? 1 : 0);
           end else if (m_pr) m_nx = 5;
        3: if (m_fr == DLY) m_nx = 4;
        4: if (m_fr == SHW || m_sr) m_nx = 0;
        5: if (m_sr) m_nx = 1; else if (m_pr) m_nx = 2;
        default: m_nx = 0;
      endcase
      m_rg = (m_nx == 1) ? 1 : 0;
      if (m_nx == 1) m_win = 0;
      if (m_nx != m_ph)                  m_fr = 0;
      else if (startOfFrame && m_fr < 511) m_fr = m_fr + 1;
      m_ph = m_nx;
      m_sk = startKey;
      m_pk = pauseKey;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stateOut",   int'(stateOut),   m_ph);
      chk("hideMap",    int'(hideMap),    (m_ph == 0) ? 1 : 0);
      chk("showEnd",    int'(showEnd),    (m_ph == 4) ? 1 : 0);
      chk("gameActive", int'(gameActive), (m_ph == 2) ? 1 : 0);
      chk("winner",     int'(winner),     m_win);
      chk("resetGame",  int'(resetGame),  m_rg);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1; step(1);
    startOfFrame = 1'b0; step(2);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; startKey = 1'b1; pauseKey = 1'b0;
    tank1Dead = 1'b0; tank2Dead = 1'b0;
    step(2);
    resetN = 1'b1;
    step(1);
    chk_en = 1'b1;

    // Key held through reset is not a press.
    chk("rst_state", int'(stateOut), 0);
    chk("rst_hide", int'(hideMap), 1);
    chk("rst_winner", int'(winner), 0);
    repeat (3) frame();
    chk("held_no_launch", int'(stateOut), 0);

    // Early start is dropped, later start launches.
    resetN = 1'b0; step(1);
    resetN = 1'b1; startKey = 1'b0; step(1);
    frame();
    startKey = 1'b1; step(1);
    chk("early_start", int'(stateOut), 0);
    startKey = 1'b0; step(1);
    frame(); frame();
    startKey = 1'b1; step(1);
    chk("launch_state", int'(stateOut), 1);
    chk("launch_rg", int'(resetGame), 1);
    step(1);
    chk("play_state", int'(stateOut), 2);
    chk("play_active", int'(gameActive), 1);
    startKey = 1'b0;

    // Kill sequence.
    tank2Dead = 1'b1; step(1); tank2Dead = 1'b0;
    chk("kill_winner", int'(winner), 1);
    chk("kill_state", int'(stateOut), 3);
    frame(); frame();
    chk("delay_hold", int'(stateOut), 3);
    frame();
    chk("end_show", int'(showEnd), 1);
    repeat (5) frame();
    chk("auto_open", int'(stateOut), 0);
    chk("open_winner_kept", int'(winner), 1);

    // Draw, ignored death during delay, early exit from end screen.
    frame(); frame();
    startKey = 1'b1; step(1);
    chk("launch_clr_win", int'(winner), 0);
    step(1); startKey = 1'b0;
    tank1Dead = 1'b1; tank2Dead = 1'b1; step(1);
    tank1Dead = 1'b0; tank2Dead = 1'b0;
    chk("draw_winner", int'(winner), 3);
    tank1Dead = 1'b1; step(1); tank1Dead = 1'b0;
    chk("delay_ignore", int'(winner), 3);
    repeat (3) frame();
    chk("draw_endshow", int'(stateOut), 4);
    frame();
    startKey = 1'b1; step(1);
    chk("early_exit", int'(stateOut), 0);
    chk("exit_winner", int'(winner), 3);
    startKey = 1'b0; step(1);

    // Reset mid-game.
    frame(); frame();
    startKey = 1'b1; step(2);
    chk("play_again", int'(stateOut), 2);
    resetN = 1'b0; step(1);
    chk("midrst_state", int'(stateOut), 0);
    chk("midrst_winner", int'(winner), 0);
    chk("midrst_rg", int'(resetGame), 0);
    resetN = 1'b1; startKey = 1'b0; step(1);

`ifdef GAME_PAUSE_EN
    frame(); frame();
    startKey = 1'b1; step(2); startKey = 1'b0;
    pauseKey = 1'b1; step(1); pauseKey = 1'b0;
    chk("pause_state", int'(stateOut), 5);
    chk("pause_inactive", int'(gameActive), 0);
    tank1Dead = 1'b1; step(1); tank1Dead = 1'b0;
    chk("pause_ignore_death", int'(stateOut), 5);
    pauseKey = 1'b1; step(1); pauseKey = 1'b0;
    chk("resume_state", int'(stateOut), 2);
    chk("resume_active", int'(gameActive), 1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      resetN       = ($urandom_range(0, 299) != 0);
      startOfFrame = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) startKey = ~startKey;
      if ($urandom_range(0, 7) == 0) pauseKey = ~pauseKey;
      tank1Dead    = ($urandom_range(0, 24) == 0);
      tank2Dead    = ($urandom_range(0, 24) == 0);
      step(1);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
